// File: rtl/load_store_buffer.sv
// ============================================================================
//  load_store_buffer
//  In-order load/store queue with a single-outstanding word-wide memory port.
//  Rev 1.0
// ============================================================================
`default_nettype none

module load_store_buffer #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [4:0]       op,
  input  logic [ROB_W-1:0] rob_number,
  input  logic [31:0]      ls_value_output,
  input  logic             flush,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_rob,
  output logic             lsb_full,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic             result_valid,
  output logic [ROB_W-1:0] result_rob,
  output logic [31:0]      result_value,
  output logic             result_exc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_COMMIT = 2'd1,
    S_REQ         = 2'd2,
    S_RESP        = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic [31:0]      r_addr_q [DEPTH];
  logic [4:0]       r_op_q   [DEPTH];
  logic [ROB_W-1:0] r_tag_q  [DEPTH];
  logic [31:0]      r_data_q [DEPTH];
  logic [DEPTH-1:0] r_valid, r_committed;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             r_req_we, r_res_exc, r_discard;
  logic [31:0]      r_req_addr, r_req_wdata, r_rdata;
  logic [3:0]       r_req_wstrb;
  logic [ROB_W-1:0] r_res_rob;
  logic [4:0]       r_res_op;
  logic [1:0]       r_res_lane;

  logic [31:0]      w_head_addr, w_head_data, w_head_wdata, w_shift, w_load_value;
  logic [4:0]       w_head_op;
  logic [ROB_W-1:0] w_head_tag;
  logic [3:0]       w_head_wstrb;
  logic [15:0]      w_half;
  logic [7:0]       w_byte;
  logic             w_head_store, w_head_misal, w_head_commit;
  logic             w_enq, w_pop, w_launch;

  assign w_head_addr   = r_addr_q[r_rd_ptr];
  assign w_head_op     = r_op_q[r_rd_ptr];
  assign w_head_tag    = r_tag_q[r_rd_ptr];
  assign w_head_data   = r_data_q[r_rd_ptr];
  assign w_head_store  = (w_head_op >= 5'd6);
  assign w_head_commit = r_committed[r_rd_ptr] || (commit_valid && (commit_rob == w_head_tag));

  assign w_pop = (r_state == S_RESP);
  assign w_enq = (rob_number != '0) && (op >= 5'd1) && (op <= 5'd8) && !flush &&
                 ((r_count < CNT_MAX) || w_pop);

  always_comb begin
    w_head_misal = 1'b0;
    w_head_wstrb = 4'b0000;
    w_head_wdata = 32'h0;
    case (w_head_op)
      5'd2, 5'd5: w_head_misal = w_head_addr[0];
      5'd3:       w_head_misal = |w_head_addr[1:0];
      5'd6: begin
        w_head_wstrb = 4'b0001 << w_head_addr[1:0];
        w_head_wdata = {4{w_head_data[7:0]}};
      end
      5'd7: begin
        w_head_misal = w_head_addr[0];
        w_head_wstrb = w_head_addr[1] ? 4'b1100 : 4'b0011;
        w_head_wdata = {2{w_head_data[15:0]}};
      end
      5'd8: begin
        w_head_misal = |w_head_addr[1:0];
        w_head_wstrb = 4'b1111;
        w_head_wdata = w_head_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush && (r_count != '0)) begin
          if (w_head_store) begin
            w_state_next = S_WAIT_COMMIT;
          end else begin
            w_launch     = 1'b1;
            w_state_next = w_head_misal ? S_RESP : S_REQ;
          end
        end
      end
      S_WAIT_COMMIT: begin
        if (flush) begin
          w_state_next = S_IDLE;
        end else if (w_head_commit) begin
          w_launch     = 1'b1;
          w_state_next = w_head_misal ? S_RESP : S_REQ;
        end
      end
      // A flushed request must still see its handshake; its response is dropped.
      S_REQ: if (mem_ready) w_state_next = (r_discard || flush) ? S_IDLE : S_RESP;
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr_q[r_wr_ptr] <= addr;
      r_op_q[r_wr_ptr]   <= op;
      r_tag_q[r_wr_ptr]  <= rob_number;
      r_data_q[r_wr_ptr] <= ls_value_output;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_committed <= '0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= '0;
      r_committed <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr          <= r_rd_ptr + 1'b1;
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (w_enq) begin
        r_wr_ptr              <= r_wr_ptr + 1'b1;
        r_valid[r_wr_ptr]     <= 1'b1;
        r_committed[r_wr_ptr] <= 1'b0;
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
      // Early commits are remembered so the head never misses its tag.
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid && r_valid[i] && (r_tag_q[i] == commit_rob) &&
            !(w_enq && (PTR_W'(i) == r_wr_ptr)))
          r_committed[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_discard   <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= 32'h0;
      r_req_wdata <= 32'h0;
      r_req_wstrb <= 4'b0000;
      r_res_rob   <= '0;
      r_res_op    <= 5'd0;
      r_res_lane  <= 2'd0;
      r_res_exc   <= 1'b0;
      r_rdata     <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_REQ) begin
        if (mem_ready)  r_discard <= 1'b0;
        else if (flush) r_discard <= 1'b1;
      end
      if (w_launch) begin
        r_req_we    <= w_head_store;
        r_req_addr  <= {w_head_addr[31:2], 2'b00};
        r_req_wdata <= w_head_wdata;
        r_req_wstrb <= w_head_wstrb;
        r_res_rob   <= w_head_tag;
        r_res_op    <= w_head_op;
        r_res_lane  <= w_head_addr[1:0];
        r_res_exc   <= w_head_misal;
        r_rdata     <= 32'h0;
      end
      if ((r_state == S_REQ) && mem_ready) r_rdata <= mem_rdata;
    end
  end

  assign w_shift = r_rdata >> {r_res_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = r_res_lane[1] ? r_rdata[31:16] : r_rdata[15:0];

  always_comb begin
    w_load_value = 32'h0;
    case (r_res_op)
      5'd1: w_load_value = {{24{w_byte[7]}}, w_byte};
      5'd2: w_load_value = {{16{w_half[15]}}, w_half};
      5'd3: w_load_value = r_rdata;
      5'd4: w_load_value = {24'h0, w_byte};
      5'd5: w_load_value = {16'h0, w_half};
      default: w_load_value = 32'h0;
    endcase
  end

  assign lsb_full     = (r_count >= CNT_FULL);
  assign mem_req      = (r_state == S_REQ);
  assign mem_we       = mem_req & r_req_we;
  assign mem_addr     = mem_req ? r_req_addr  : 32'h0;
  assign mem_wdata    = mem_req ? r_req_wdata : 32'h0;
  assign mem_wstrb    = mem_req ? r_req_wstrb : 4'b0000;
  assign result_valid = (r_state == S_RESP);
  assign result_rob   = result_valid ? r_res_rob : '0;
  assign result_exc   = result_valid & r_res_exc;
  assign result_value = (result_valid && !r_res_exc) ? w_load_value : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_load_store_buffer.sv
// ============================================================================
//  tb_load_store_buffer
//  Directed self-checking bench for load_store_buffer.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_load_store_buffer;

  localparam int ROB_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      addr;
  logic [4:0]       op;
  logic [ROB_W-1:0] rob_number;
  logic [31:0]      ls_value_output;
  logic             flush, commit_valid, mem_ready;
  logic [ROB_W-1:0] commit_rob;
  logic [31:0]      mem_rdata;
  logic             lsb_full, mem_req, mem_we, result_valid, result_exc;
  logic [31:0]      mem_addr, mem_wdata, result_value;
  logic [3:0]       mem_wstrb;
  logic [ROB_W-1:0] result_rob;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_buffer #(.DEPTH(4), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .op(op), .rob_number(rob_number),
    .ls_value_output(ls_value_output), .flush(flush),
    .commit_valid(commit_valid), .commit_rob(commit_rob),
    .lsb_full(lsb_full), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .result_valid(result_valid), .result_rob(result_rob),
    .result_value(result_value), .result_exc(result_exc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [4:0] o, input logic [31:0] a,
                     input logic [ROB_W-1:0] t, input logic [31:0] d);
    op = o; addr = a; rob_number = t; ls_value_output = d;
    tick();
    op = 5'd0; rob_number = '0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'h0, mem_req}, 32'h1);
  endtask

  task automatic respond(input logic [31:0] d);
    mem_rdata = d; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [ROB_W-1:0] t,
                               input logic [31:0] v);
    check({tag, "_valid"}, {31'h0, result_valid}, 32'h1);
    check({tag, "_rob"},   {29'h0, result_rob},   {29'h0, t});
    check({tag, "_value"}, result_value, v);
  endtask

  task automatic load(input string tag, input logic [4:0] o, input logic [31:0] a,
                      input logic [ROB_W-1:0] t, input logic [31:0] rd,
                      input logic [31:0] v);
    enq(o, a, t, 32'h0);
    wait_req({tag, "_req"});
    check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    respond(rd);
    expect_result(tag, t, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic saw_req;
    int   n;

    rst = 1'b0; addr = 32'h0; op = 5'd0; rob_number = '0; ls_value_output = 32'h0;
    flush = 1'b0; commit_valid = 1'b0; commit_rob = '0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #2;
    check("rst_mem_req",  {31'h0, mem_req},      32'h0);
    check("rst_result",   {31'h0, result_valid}, 32'h0);
    check("rst_full",     {31'h0, lsb_full},     32'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // LW: request on the second edge after sampling
    enq(5'd3, 32'h100, 3'd3, 32'h0);
    check("lw_lat_early", {31'h0, mem_req}, 32'h0);
    tick();
    check("lw_lat_req",   {31'h0, mem_req}, 32'h1);
    check("lw_addr",      mem_addr, 32'h100);
    check("lw_we",        {31'h0, mem_we}, 32'h0);
    respond(32'hDEADBEEF);
    expect_result("lw", 3'd3, 32'hDEADBEEF);
    check("lw_exc", {31'h0, result_exc}, 32'h0);
    tick();
    check("lw_pulse_end", {31'h0, result_valid}, 32'h0);

    load("lb",  5'd1, 32'h103, 3'd1, 32'h80000000, 32'hFFFFFF80);
    load("lbu", 5'd4, 32'h103, 3'd2, 32'h80000000, 32'h00000080);
    load("lh",  5'd2, 32'h102, 3'd4, 32'h80010000, 32'hFFFF8001);
    load("lhu", 5'd5, 32'h100, 3'd6, 32'h1234F00D, 32'h0000F00D);

    // SH waits for its commit
    enq(5'd7, 32'h202, 3'd5, 32'h00001234);
    saw_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saw_req |= mem_req;
      tick();
    end
    check("sh_no_req", {31'h0, saw_req}, 32'h0);
    commit_valid = 1'b1; commit_rob = 3'd5;
    tick();
    commit_valid = 1'b0; commit_rob = '0;
    check("sh_req",   {31'h0, mem_req}, 32'h1);
    check("sh_we",    {31'h0, mem_we},  32'h1);
    check("sh_addr",  mem_addr,  32'h200);
    check("sh_wstrb", {28'h0, mem_wstrb}, 32'hC);
    check("sh_wdata", mem_wdata, 32'h12341234);
    respond(32'hFFFFFFFF);
    expect_result("sh", 3'd5, 32'h0);

    // Four loads with memory stalled; fifth is dropped
    enq(5'd3, 32'h10, 3'd1, 32'h0);
    enq(5'd3, 32'h14, 3'd2, 32'h0);
    check("full_at2", {31'h0, lsb_full}, 32'h0);
    enq(5'd3, 32'h18, 3'd3, 32'h0);
    check("full_at3", {31'h0, lsb_full}, 32'h1);
    enq(5'd3, 32'h1C, 3'd4, 32'h0);
    enq(5'd3, 32'h20, 3'd5, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      wait_req("q_req");
      check("q_addr", mem_addr, 32'h10 + 32'(4 * (k - 1)));
      respond(32'h1000 + 32'(k));
      expect_result("q", ROB_W'(k), 32'h1000 + 32'(k));
    end
    saw_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_req |= mem_req;
    end
    check("q_drop5", {31'h0, saw_req}, 32'h0);
    check("q_empty_full", {31'h0, lsb_full}, 32'h0);

    // Early commit of a store queued behind a stalled load
    enq(5'd3, 32'h20, 3'd1, 32'h0);
    enq(5'd6, 32'h301, 3'd2, 32'h000000AB);
    wait_req("ec_ld_req");
    commit_valid = 1'b1; commit_rob = 3'd2;
    tick();
    commit_valid = 1'b0; commit_rob = '0;
    respond(32'h55);
    expect_result("ec_ld", 3'd1, 32'h55);
    wait_req("ec_st_req");
    check("ec_st_addr",  mem_addr, 32'h300);
    check("ec_st_wstrb", {28'h0, mem_wstrb}, 32'h2);
    check("ec_st_wdata", mem_wdata, 32'hABABABAB);
    respond(32'h0);
    expect_result("ec_st", 3'd2, 32'h0);

    // Flush during REQ: handshake completes, response dropped
    enq(5'd3, 32'h40, 3'd6, 32'h0);
    wait_req("fl_req");
    flush = 1'b1; op = 5'd3; addr = 32'h44; rob_number = 3'd7;
    tick();
    flush = 1'b0; op = 5'd0; rob_number = '0;
    check("fl_hold_req",  {31'h0, mem_req}, 32'h1);
    check("fl_hold_addr", mem_addr, 32'h40);
    respond(32'h77);
    check("fl_no_result", {31'h0, result_valid}, 32'h0);
    saw_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_req |= mem_req | result_valid;
    end
    check("fl_empty", {31'h0, saw_req}, 32'h0);

    // Misaligned LW: exception, no memory request
    enq(5'd3, 32'h101, 3'd2, 32'h0);
    saw_req = 1'b0;
    n = 0;
    while (!result_valid && n < 6) begin
      saw_req |= mem_req;
      tick();
      n++;
    end
    check("mis_no_req", {31'h0, saw_req}, 32'h0);
    expect_result("mis", 3'd2, 32'h0);
    check("mis_exc", {31'h0, result_exc}, 32'h1);

    // Asynchronous reset while a request is outstanding
    tick();
    enq(5'd3, 32'h80, 3'd1, 32'h0);
    wait_req("ar_req");
    #2;
    rst = 1'b0;
    #1;
    check("ar_mem_req",  {31'h0, mem_req}, 32'h0);
    check("ar_mem_addr", mem_addr, 32'h0);
    check("ar_full",     {31'h0, lsb_full}, 32'h0);
    tick();
    rst = 1'b1;
    saw_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      saw_req |= mem_req | result_valid;
    end
    check("ar_empty", {31'h0, saw_req}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
